// File: rtl/fir_pkg.sv
// Shared widths, byte-phase encoding and sample packing for the FIR input stage.
package fir_pkg;
   localparam int DATA_W    = 16;
   localparam int BYTE_W    = 8;
   localparam int DEF_DEPTH = 4;

   typedef enum logic {
      PH_LOW  = 1'b0,
      PH_HIGH = 1'b1
   } phase_e;

   // Samples arrive low byte first; the pair is concatenated without arithmetic.
   function automatic logic [DATA_W-1:0] join_bytes(input logic [BYTE_W-1:0] hi,
                                                    input logic [BYTE_W-1:0] lo);
      return {hi, lo};
   endfunction
endpackage

// File: rtl/fir_in_fifo.sv
// Small sample FIFO: registered storage, pointers carry an extra wrap bit.
module fir_in_fifo #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] din,
   output logic              full,
   output logic              empty,
   output logic [DATA_W-1:0] dout
);
   localparam int AW = $clog2(DEPTH);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [AW:0]       r_wr_ptr;
   logic [AW:0]       r_rd_ptr;
   logic              w_wr_en;
   logic              w_rd_en;

   assign empty = (r_wr_ptr == r_rd_ptr);
   assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                  (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   // A push into a full FIFO only lands when the head leaves on the same edge.
   assign w_wr_en = push & (~full | pop);
   assign w_rd_en = pop & ~empty;
   assign dout    = r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= {(AW+1){1'b0}};
         r_rd_ptr <= {(AW+1){1'b0}};
      end else begin
         if (w_wr_en) r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
         if (w_rd_en) r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= din;
   end
endmodule

// File: rtl/fir_sample_loader.sv
// Pin-level byte loader for the FIR core: synchronizes strobes, pairs bytes into samples, queues them.
// Optional FIR_LOADER_DROP_CNT_EN adds a saturating dropped-sample counter on drop_cnt_o.
module fir_sample_loader
   import fir_pkg::*;
#(
   parameter int DEPTH       = DEF_DEPTH,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [BYTE_W-1:0] byte_i,
   input  logic              strb_i,
   input  logic              sync_i,
   output logic [DATA_W-1:0] smp_o,
   output logic              smp_vld_o,
   input  logic              smp_rdy_i,
   output logic              phase_o,
   output logic              full_o,
`ifdef FIR_LOADER_DROP_CNT_EN
   output logic [7:0]        drop_cnt_o,
`endif
   output logic              ovf_o
);
   logic [SYNC_STAGES-1:0] r_strb_sync;
   logic [SYNC_STAGES-1:0] r_sync_sync;
   logic                   r_strb_edge;
   phase_e                 r_state;
   logic [BYTE_W-1:0]      r_lo;
   logic                   r_ovf;
   logic                   w_rise;
   logic                   w_realign;
   logic                   w_push;
   logic                   w_pop;
   logic                   w_drop;
   logic                   w_full;
   logic                   w_empty;
   logic [DATA_W-1:0]      w_dout;

   assign w_rise    = r_strb_sync[SYNC_STAGES-1] & ~r_strb_edge;
   assign w_realign = r_sync_sync[SYNC_STAGES-1];
   // Realign beats a coincident strobe, so that byte never reaches the FIFO.
   assign w_push    = w_rise & ~w_realign & (r_state == PH_HIGH);
   assign w_pop     = smp_vld_o & smp_rdy_i;
   assign w_drop    = w_push & w_full & ~w_pop;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_strb_sync <= {SYNC_STAGES{1'b0}};
         r_sync_sync <= {SYNC_STAGES{1'b0}};
         r_strb_edge <= 1'b0;
      end else begin
         r_strb_sync <= {r_strb_sync[SYNC_STAGES-2:0], strb_i};
         r_sync_sync <= {r_sync_sync[SYNC_STAGES-2:0], sync_i};
         r_strb_edge <= r_strb_sync[SYNC_STAGES-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= PH_LOW;
         r_lo    <= {BYTE_W{1'b0}};
      end else if (w_realign) begin
         r_state <= PH_LOW;
         r_lo    <= {BYTE_W{1'b0}};
      end else if (w_rise) begin
         case (r_state)
            PH_LOW: begin
               r_lo    <= byte_i;
               r_state <= PH_HIGH;
            end
            PH_HIGH: r_state <= PH_LOW;
            default: r_state <= PH_LOW;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst)         r_ovf <= 1'b0;
      else if (w_drop) r_ovf <= 1'b1;
   end

`ifdef FIR_LOADER_DROP_CNT_EN
   logic [7:0] r_drop_cnt;

   always_ff @(posedge clk) begin
      if (rst)                                r_drop_cnt <= 8'd0;
      else if (w_drop && r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
   end

   assign drop_cnt_o = r_drop_cnt;
`endif

   fir_in_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (w_push),
      .pop   (w_pop),
      .din   (join_bytes(byte_i, r_lo)),
      .full  (w_full),
      .empty (w_empty),
      .dout  (w_dout)
   );

   assign smp_o     = w_dout;
   assign smp_vld_o = ~w_empty;
   assign full_o    = w_full;
   assign phase_o   = (r_state == PH_HIGH);
   assign ovf_o     = r_ovf;
endmodule

// File: tb/tb_fir_sample_loader.sv
// Scoreboard bench for fir_sample_loader; expected samples are queued as bytes are strobed in.
module tb_fir_sample_loader;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  byte_i = 8'h00;
   logic        strb_i = 1'b0;
   logic        sync_i = 1'b0;
   logic        smp_rdy_i = 1'b0;
   logic [15:0] smp_o;
   logic        smp_vld_o;
   logic        phase_o;
   logic        full_o;
   logic        ovf_o;
`ifdef FIR_LOADER_DROP_CNT_EN
   logic [7:0]  drop_cnt_o;
`endif

   int          checks = 0;
   int          errors = 0;
   int          pop_cnt = 0;
   logic [15:0] exp_q[$];

   always #5 clk = ~clk;

   fir_sample_loader dut (
      .clk       (clk),
      .rst       (rst),
      .byte_i    (byte_i),
      .strb_i    (strb_i),
      .sync_i    (sync_i),
      .smp_o     (smp_o),
      .smp_vld_o (smp_vld_o),
      .smp_rdy_i (smp_rdy_i),
      .phase_o   (phase_o),
      .full_o    (full_o),
`ifdef FIR_LOADER_DROP_CNT_EN
      .drop_cnt_o(drop_cnt_o),
`endif
      .ovf_o     (ovf_o)
   );

   // Scoreboard: every handshake the DUT completes must match the queue head.
   always @(negedge clk) begin
      logic [15:0] e;
      #1;
      if (!rst && smp_vld_o && smp_rdy_i) begin
         checks++;
         pop_cnt++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL pop_unexpected got %h expected none", smp_o);
         end else begin
            e = exp_q.pop_front();
            if (smp_o !== e) begin
               errors++;
               $display("FAIL pop_data got %h expected %h", smp_o, e);
            end
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input int hold);
      byte_i = b;
      repeat (4) @(negedge clk);
      strb_i = 1'b1;
      repeat (hold) @(negedge clk);
      strb_i = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      @(negedge clk);
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({smp_vld_o, phase_o, full_o, ovf_o} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_state got %b expected 0000", {smp_vld_o, phase_o, full_o, ovf_o});
      end
   endtask

   task automatic test_basic();
      int p0;
      smp_rdy_i = 1'b1;
      p0 = pop_cnt;
      send_byte(8'h34, 5);
      checks++;
      if (phase_o !== 1'b1 || smp_vld_o !== 1'b0) begin
         errors++;
         $display("FAIL basic_phase got phase=%b vld=%b expected phase=1 vld=0", phase_o, smp_vld_o);
      end
      exp_q.push_back(16'h1234);
      send_byte(8'h12, 5);
      checks++;
      if (pop_cnt - p0 != 1 || exp_q.size() != 0 || phase_o !== 1'b0) begin
         errors++;
         $display("FAIL basic_pop got pops=%0d left=%0d phase=%b expected 1 0 0",
                  pop_cnt - p0, exp_q.size(), phase_o);
      end
   endtask

   task automatic test_overflow();
      do_reset();
      smp_rdy_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (i < 4) exp_q.push_back({8'h80 + 8'(i), 8'h10 + 8'(i)});
         send_byte(8'h10 + 8'(i), 5);
         send_byte(8'h80 + 8'(i), 5);
         if (i == 3) begin
            checks++;
            if (full_o !== 1'b1 || ovf_o !== 1'b0) begin
               errors++;
               $display("FAIL ovf_full4 got full=%b ovf=%b expected 1 0", full_o, ovf_o);
            end
         end
      end
      checks++;
      if (full_o !== 1'b1 || ovf_o !== 1'b1) begin
         errors++;
         $display("FAIL ovf_drop got full=%b ovf=%b expected 1 1", full_o, ovf_o);
      end
      smp_rdy_i = 1'b1;
      repeat (10) @(negedge clk);
      smp_rdy_i = 1'b0;
      checks++;
      if (exp_q.size() != 0 || smp_vld_o !== 1'b0 || full_o !== 1'b0 || ovf_o !== 1'b1) begin
         errors++;
         $display("FAIL ovf_drain got left=%0d vld=%b full=%b ovf=%b expected 0 0 0 1",
                  exp_q.size(), smp_vld_o, full_o, ovf_o);
      end
   endtask

   task automatic test_push_pop_full();
      do_reset();
      smp_rdy_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back({8'h40 + 8'(i), 8'h20 + 8'(i)});
         send_byte(8'h20 + 8'(i), 5);
         send_byte(8'h40 + 8'(i), 5);
      end
      send_byte(8'h66, 5);
      // High-byte capture lands on the third edge after the strobe; pop on that same edge.
      byte_i = 8'h99;
      repeat (4) @(negedge clk);
      strb_i = 1'b1;
      @(negedge clk);
      exp_q.push_back(16'h9966);
      @(negedge clk);
      smp_rdy_i = 1'b1;
      @(negedge clk);
      smp_rdy_i = 1'b0;
      repeat (3) @(negedge clk);
      strb_i = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (full_o !== 1'b1 || ovf_o !== 1'b0 || exp_q.size() != 4) begin
         errors++;
         $display("FAIL pushpop_full got full=%b ovf=%b left=%0d expected 1 0 4",
                  full_o, ovf_o, exp_q.size());
      end
      smp_rdy_i = 1'b1;
      repeat (8) @(negedge clk);
      smp_rdy_i = 1'b0;
      checks++;
      if (exp_q.size() != 0 || smp_vld_o !== 1'b0) begin
         errors++;
         $display("FAIL pushpop_drain got left=%0d vld=%b expected 0 0", exp_q.size(), smp_vld_o);
      end
   endtask

   task automatic test_realign();
      do_reset();
      smp_rdy_i = 1'b1;
      send_byte(8'hAA, 5);
      sync_i = 1'b1;
      repeat (4) @(negedge clk);
      sync_i = 1'b0;
      repeat (4) @(negedge clk);
      checks++;
      if (phase_o !== 1'b0 || smp_vld_o !== 1'b0) begin
         errors++;
         $display("FAIL realign_phase got phase=%b vld=%b expected 0 0", phase_o, smp_vld_o);
      end
      send_byte(8'h11, 5);
      exp_q.push_back(16'h2211);
      send_byte(8'h22, 5);
      checks++;
      if (exp_q.size() != 0 || phase_o !== 1'b0) begin
         errors++;
         $display("FAIL realign_sample got left=%0d phase=%b expected 0 0", exp_q.size(), phase_o);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      smp_rdy_i = 1'b0;
      send_byte(8'h01, 5);
      send_byte(8'h02, 5);
      send_byte(8'h03, 5);
      send_byte(8'h04, 5);
      send_byte(8'h05, 5);
      checks++;
      if (phase_o !== 1'b1 || smp_vld_o !== 1'b1) begin
         errors++;
         $display("FAIL midrst_pre got phase=%b vld=%b expected 1 1", phase_o, smp_vld_o);
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({smp_vld_o, phase_o, ovf_o, full_o} !== 4'b0000) begin
         errors++;
         $display("FAIL midrst_state got %b expected 0000", {smp_vld_o, phase_o, ovf_o, full_o});
      end
      rst = 1'b0;
      smp_rdy_i = 1'b1;
      repeat (4) @(negedge clk);
      checks++;
      if (smp_vld_o !== 1'b0) begin
         errors++;
         $display("FAIL midrst_after got vld=%b expected 0", smp_vld_o);
      end
   endtask

   task automatic test_long_strobe();
      do_reset();
      smp_rdy_i = 1'b1;
      send_byte(8'h5A, 20);
      checks++;
      if (phase_o !== 1'b1) begin
         errors++;
         $display("FAIL long_strobe got phase=%b expected 1", phase_o);
      end
      exp_q.push_back(16'hC35A);
      send_byte(8'hC3, 5);
      checks++;
      if (exp_q.size() != 0 || phase_o !== 1'b0) begin
         errors++;
         $display("FAIL long_sample got left=%0d phase=%b expected 0 0", exp_q.size(), phase_o);
      end
   endtask

`ifdef FIR_LOADER_DROP_CNT_EN
   task automatic test_drop_cnt();
      do_reset();
      smp_rdy_i = 1'b0;
      for (int i = 0; i < 304; i++) begin
         send_byte(8'(i), 3);
         send_byte(8'(i + 7), 3);
         if (i == 13) begin
            checks++;
            if (drop_cnt_o !== 8'd10) begin
               errors++;
               $display("FAIL drop_cnt_mid got %0d expected 10", drop_cnt_o);
            end
         end
      end
      checks++;
      if (drop_cnt_o !== 8'd255 || ovf_o !== 1'b1) begin
         errors++;
         $display("FAIL drop_cnt_sat got %0d ovf=%b expected 255 1", drop_cnt_o, ovf_o);
      end
      do_reset();
      checks++;
      if (drop_cnt_o !== 8'd0) begin
         errors++;
         $display("FAIL drop_cnt_rst got %0d expected 0", drop_cnt_o);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_overflow();
      test_push_pop_full();
      test_realign();
      test_reset_mid();
      test_long_strobe();
`ifdef FIR_LOADER_DROP_CNT_EN
      test_drop_cnt();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
